// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC generator with a direct-mapped BTB, feeding the bimodal predictor.
// Chooses sequential, BTB-predicted or execute-redirect next PC and paces predictor updates.
module fetch_pc_unit #(
    parameter int          BTB_INDEX_WIDTH = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] pc_predict,
    input  logic        prediction,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_is_cond,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic        flush,
    output logic [31:0] pc_update,
    output logic        update,
    output logic        taken,
    output logic [31:0] mispredict_count,
    output logic [31:0] cond_branch_count
);

    localparam int ENTRIES = 1 << BTB_INDEX_WIDTH;
    localparam int TAG_W   = 30 - BTB_INDEX_WIDTH;

    logic [31:0]                r_pc;
    logic                       r_bubble;
    logic [ENTRIES-1:0]         r_btb_valid;
    logic [ENTRIES-1:0]         r_btb_jump;
    logic [TAG_W-1:0]           r_btb_tag    [ENTRIES];
    logic [31:0]                r_btb_target [ENTRIES];
    logic                       r_update;
    logic [31:0]                r_pc_update;
    logic                       r_taken;
    logic [31:0]                r_mispredict_count;
    logic [31:0]                r_cond_branch_count;

    logic [BTB_INDEX_WIDTH-1:0] w_lk_idx;
    logic [TAG_W-1:0]           w_lk_tag;
    logic [BTB_INDEX_WIDTH-1:0] w_wr_idx;
    logic [TAG_W-1:0]           w_wr_tag;
    logic                       w_hit;
    logic                       w_pc_valid;
    logic                       w_pred_taken;
    logic [31:0]                w_seq;
    logic [31:0]                w_pred_target;
    logic                       w_mispredict;
    logic                       w_btb_we;
    logic                       w_cond_res;
    logic [31:0]                w_pc_predict;

    assign w_lk_idx = r_pc[BTB_INDEX_WIDTH+1:2];
    assign w_lk_tag = r_pc[31:BTB_INDEX_WIDTH+2];
    assign w_wr_idx = res_pc[BTB_INDEX_WIDTH+1:2];
    assign w_wr_tag = res_pc[31:BTB_INDEX_WIDTH+2];

    assign w_hit         = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign w_pc_valid    = rstn && !r_bubble;
    assign w_pred_taken  = w_pc_valid && w_hit && (r_btb_jump[w_lk_idx] || prediction);
    assign w_seq         = r_pc + 32'd4;
    assign w_pred_target = w_pred_taken ? r_btb_target[w_lk_idx] : w_seq;

    // Resolutions seen while in reset must not redirect, allocate or count.
    assign w_mispredict = rstn && res_valid &&
                          ((res_taken != res_pred_taken) ||
                           (res_taken && (res_target != res_pred_target)));
    assign w_btb_we     = rstn && res_valid && res_taken;
    assign w_cond_res   = rstn && res_valid && res_is_cond;

    always_comb begin
        w_pc_predict = w_pred_target;
        if (!rstn)
            w_pc_predict = RESET_PC;
        else if (w_mispredict)
            w_pc_predict = res_taken ? res_target : (res_pc + 32'd4);
        else if (stall)
            w_pc_predict = r_pc;
    end

    // The bubble flag marks the redirect cycle as an invalid fetch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc     <= RESET_PC;
            r_bubble <= 1'b0;
        end else begin
            r_pc     <= w_pc_predict;
            r_bubble <= w_mispredict;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_btb_valid <= '0;
            r_btb_jump  <= '0;
        end else if (w_btb_we) begin
            r_btb_valid[w_wr_idx] <= 1'b1;
            r_btb_jump[w_wr_idx]  <= !res_is_cond;
        end
    end

    always_ff @(posedge clk) begin
        if (w_btb_we) begin
            r_btb_tag[w_wr_idx]    <= w_wr_tag;
            r_btb_target[w_wr_idx] <= res_target;
        end
    end

    // A conditional resolution landing on an active update pulse is dropped for the predictor.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_update    <= 1'b0;
            r_pc_update <= '0;
            r_taken     <= 1'b0;
        end else if (w_cond_res && !r_update) begin
            r_update    <= 1'b1;
            r_pc_update <= res_pc;
            r_taken     <= res_taken;
        end else begin
            r_update    <= 1'b0;
            r_pc_update <= '0;
            r_taken     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mispredict_count  <= '0;
            r_cond_branch_count <= '0;
        end else begin
            if (w_mispredict)
                r_mispredict_count <= r_mispredict_count + 32'd1;
            if (w_cond_res)
                r_cond_branch_count <= r_cond_branch_count + 32'd1;
        end
    end

    assign pc                = r_pc;
    assign pc_valid          = w_pc_valid;
    assign pred_taken        = w_pred_taken;
    assign pred_target       = w_pred_target;
    assign pc_predict        = w_pc_predict;
    assign flush             = w_mispredict;
    assign pc_update         = r_pc_update;
    assign update            = r_update;
    assign taken             = r_taken;
    assign mispredict_count  = r_mispredict_count;
    assign cond_branch_count = r_cond_branch_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed fetch/redirect checks plus a
// scoreboard of expected predictor update pulses.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        prediction = 1'b0;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic        res_is_cond = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_pred_target = '0;

    logic [31:0] pc;
    logic        pc_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pc_predict;
    logic        flush;
    logic [31:0] pc_update;
    logic        update;
    logic        taken;
    logic [31:0] mispredict_count;
    logic [31:0] cond_branch_count;

    fetch_pc_unit #(
        .BTB_INDEX_WIDTH(4),
        .RESET_PC       (32'h0000_0100)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .stall            (stall),
        .pc               (pc),
        .pc_valid         (pc_valid),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pc_predict       (pc_predict),
        .prediction       (prediction),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_is_cond      (res_is_cond),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .res_pred_taken   (res_pred_taken),
        .res_pred_target  (res_pred_target),
        .flush            (flush),
        .pc_update        (pc_update),
        .update           (update),
        .taken            (taken),
        .mispredict_count (mispredict_count),
        .cond_branch_count(cond_branch_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pcu;
        logic        tk;
    } upd_t;

    upd_t updQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   lastAcc = 1'b0;
    bit   monEn = 1'b0;
    bit   prevUpd = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; returns just before the next falling edge so that
    // combinational outputs for this cycle can be sampled.
    task automatic applyStimulus(input logic rn, input logic st, input logic pr,
                                 input logic rv, input logic cond, input logic tk,
                                 input logic [31:0] rpc, input logic [31:0] tgt,
                                 input logic ptk, input logic [31:0] ptgt);
        @(posedge clk);
        #1;
        rstn            = rn;
        stall           = st;
        prediction      = pr;
        res_valid       = rv;
        res_is_cond     = cond;
        res_taken       = tk;
        res_pc          = rpc;
        res_target      = tgt;
        res_pred_taken  = ptk;
        res_pred_target = ptgt;
        if (rn && rv && cond && !lastAcc) begin
            updQ.push_back('{pcu: rpc, tk: tk});
            lastAcc = 1'b1;
        end else begin
            lastAcc = 1'b0;
        end
        #3;
    endtask

    task automatic idle(input logic st, input logic pr);
        applyStimulus(1'b1, st, pr, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Scoreboard side: every update pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (monEn) begin
            if (update) begin
                checkOutput("upd_b2b", 32'(prevUpd), 32'd0);
                if (updQ.size() == 0) begin
                    checkOutput("upd_spurious", 32'(update), 32'd0);
                end else begin
                    upd_t e;
                    e = updQ.pop_front();
                    checkOutput("upd_pc", pc_update, e.pcu);
                    checkOutput("upd_taken", 32'(taken), 32'(e.tk));
                end
            end else begin
                checkOutput("upd_idle_pc", pc_update, 32'd0);
                checkOutput("upd_idle_tk", 32'(taken), 32'd0);
            end
            prevUpd = update;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset, including a resolution that must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        monEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 1'b0, 32'h108);
        checkOutput("rst_flush", 32'(flush), 32'd0);
        checkOutput("rst_pc", pc, 32'h100);
        checkOutput("rst_valid", 32'(pc_valid), 32'd0);
        checkOutput("rst_pcpred", pc_predict, 32'h100);

        // Sequential fetch after release.
        idle(1'b0, 1'b0);
        checkOutput("seq0_pc", pc, 32'h100);
        checkOutput("seq0_valid", 32'(pc_valid), 32'd1);
        checkOutput("seq0_pcpred", pc_predict, 32'h104);
        checkOutput("seq0_cond_cnt", cond_branch_count, 32'd0);
        checkOutput("seq0_mis_cnt", mispredict_count, 32'd0);
        idle(1'b0, 1'b0);
        checkOutput("seq1_pc", pc, 32'h104);
        checkOutput("seq1_valid", 32'(pc_valid), 32'd1);
        idle(1'b0, 1'b0);
        checkOutput("seq2_pc", pc, 32'h108);

        // Taken conditional at 0x104 -> 0x200, predicted not taken.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 1'b0, 32'h108);
        checkOutput("mp1_pc", pc, 32'h10C);
        checkOutput("mp1_flush", 32'(flush), 32'd1);
        checkOutput("mp1_pcpred", pc_predict, 32'h200);

        // Not-taken conditional at 0x100 predicted taken: redirect to 0x104; update dropped.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h180, 1'b1, 32'h180);
        checkOutput("mp1_next_pc", pc, 32'h200);
        checkOutput("mp1_next_valid", 32'(pc_valid), 32'd0);
        checkOutput("mp1_mis_cnt", mispredict_count, 32'd1);
        checkOutput("mp1_cond_cnt", cond_branch_count, 32'd1);
        checkOutput("mp2_flush", 32'(flush), 32'd1);
        checkOutput("mp2_pcpred", pc_predict, 32'h104);

        // Stall in the bubble holds the redirect PC.
        idle(1'b1, 1'b0);
        checkOutput("bub_pc", pc, 32'h104);
        checkOutput("bub_valid", 32'(pc_valid), 32'd0);
        checkOutput("bub_ptaken", 32'(pred_taken), 32'd0);
        checkOutput("bub_pcpred", pc_predict, 32'h104);

        // BTB hit on 0x104: prediction 0 then 1.
        idle(1'b1, 1'b0);
        checkOutput("btb_n_pc", pc, 32'h104);
        checkOutput("btb_n_valid", 32'(pc_valid), 32'd1);
        checkOutput("btb_n_ptaken", 32'(pred_taken), 32'd0);
        checkOutput("btb_n_ptgt", pred_target, 32'h108);
        checkOutput("btb_n_pcpred", pc_predict, 32'h104);
        checkOutput("mp2_mis_cnt", mispredict_count, 32'd2);
        checkOutput("mp2_cond_cnt", cond_branch_count, 32'd2);
        idle(1'b0, 1'b1);
        checkOutput("btb_t_ptaken", 32'(pred_taken), 32'd1);
        checkOutput("btb_t_ptgt", pred_target, 32'h200);
        checkOutput("btb_t_pcpred", pc_predict, 32'h200);
        idle(1'b0, 1'b0);
        checkOutput("btb_t_next_pc", pc, 32'h200);

        // jal 0x300 -> 0x40, then redirect back to 0x300 via a jal with a wrong target.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h40, 1'b0, 32'h304);
        checkOutput("jal_pc", pc, 32'h204);
        checkOutput("jal_flush", 32'(flush), 32'd1);
        checkOutput("jal_pcpred", pc_predict, 32'h40);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3A0, 32'h300, 1'b1, 32'h100);
        checkOutput("jtgt_flush", 32'(flush), 32'd1);
        checkOutput("jtgt_pcpred", pc_predict, 32'h300);
        idle(1'b1, 1'b0);
        checkOutput("jal_bub_pc", pc, 32'h300);
        idle(1'b0, 1'b0);
        checkOutput("jal_ref_valid", 32'(pc_valid), 32'd1);
        checkOutput("jal_ref_ptaken", 32'(pred_taken), 32'd1);
        checkOutput("jal_ref_ptgt", pred_target, 32'h40);
        checkOutput("jal_ref_pcpred", pc_predict, 32'h40);
        checkOutput("jal_mis_cnt", mispredict_count, 32'd4);
        checkOutput("jal_cond_cnt", cond_branch_count, 32'd2);
        idle(1'b0, 1'b0);
        checkOutput("jal_next_pc", pc, 32'h40);

        // Back-to-back correctly predicted conditionals: one update pulse only.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h80, 1'b1, 32'h80);
        checkOutput("b2b0_flush", 32'(flush), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h24);
        checkOutput("b2b1_flush", 32'(flush), 32'd0);
        idle(1'b0, 1'b0);
        checkOutput("b2b_pc", pc, 32'h4C);
        checkOutput("b2b_cond_cnt", cond_branch_count, 32'd4);
        checkOutput("b2b_mis_cnt", mispredict_count, 32'd4);

        // Mispredict overrides stall, then a 3-cycle stall holds everything.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4FC, 32'h600, 1'b1, 32'h600);
        checkOutput("stmp_flush", 32'(flush), 32'd1);
        checkOutput("stmp_pcpred", pc_predict, 32'h500);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b0);
            checkOutput("stall_pc", pc, 32'h500);
            checkOutput("stall_pcpred", pc_predict, 32'h500);
            checkOutput("stall_valid", 32'(pc_valid), (i == 0) ? 32'd0 : 32'd1);
        end
        idle(1'b0, 1'b0);
        checkOutput("unstall_pcpred", pc_predict, 32'h504);
        checkOutput("stmp_mis_cnt", mispredict_count, 32'd5);
        checkOutput("stmp_cond_cnt", cond_branch_count, 32'd5);

        // Sequential wrap at the top of the address space.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 32'hFFFF_FFFC, 1'b0, 32'h604);
        checkOutput("wrap_pcpred0", pc_predict, 32'hFFFF_FFFC);
        idle(1'b0, 1'b0);
        checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pcpred", pc_predict, 32'h0);
        idle(1'b0, 1'b0);
        checkOutput("wrap_next_pc", pc, 32'h0);

        // Reset during a mispredicting resolve discards it and clears the BTB.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h700, 32'h800, 1'b0, 32'h704);
        checkOutput("rst2_flush", 32'(flush), 32'd0);
        checkOutput("rst2_pcpred", pc_predict, 32'h100);
        idle(1'b0, 1'b1);
        checkOutput("rst2_pc", pc, 32'h100);
        checkOutput("rst2_valid", 32'(pc_valid), 32'd1);
        checkOutput("rst2_mis_cnt", mispredict_count, 32'd0);
        checkOutput("rst2_cond_cnt", cond_branch_count, 32'd0);
        idle(1'b0, 1'b1);
        checkOutput("rst2_btb_pc", pc, 32'h104);
        checkOutput("rst2_btb_ptaken", 32'(pred_taken), 32'd0);
        checkOutput("rst2_btb_pcpred", pc_predict, 32'h108);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        checkOutput("updq_empty", 32'(updQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
